hamming_decoder: RTL

- Decode side of the team's shortened SEC-DED (odd-weight-column) Hamming code.
- Accepts one right-aligned codeword per cycle in one of three sizes: 8-bit Small, 16-bit Medium or 32-bit Large.
- Recomputes the check bits, forms the syndrome, corrects any single-bit error and flags double/uncorrectable errors.
- Two-stage pipeline between the register file and the APB-side output register; keeps saturating error statistics.

---
 rtl/hamming_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hamming_decoder.sv
// SEC-DED decoder for the shortened odd-weight-column Hamming code (8/16/32-bit codewords).
// Stage 1 forms the syndrome, stage 2 classifies/corrects, then the output register and error counters.
module hamming_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int AMBA_WORD  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 START,
   input  logic [1:0]           CODEWORD_WIDTH,
   input  logic [AMBA_WORD-1:0] DATA_IN,
   input  logic                 CLR_CNT,
   output logic [AMBA_WORD-1:0] DATA_OUT,
   output logic [1:0]           NUM_OF_ERRORS,
   output logic                 VALID_OUT,
   output logic [CNT_WIDTH-1:0] CORR_CNT,
   output logic [CNT_WIDTH-1:0] UNCORR_CNT
);

   // Handshake: no backpressure. A word is accepted on every rising edge with START=1;
   // its result is presented for exactly one cycle with VALID_OUT=1, two edges later, in order.

   localparam int KMAX = DATA_WIDTH - 6;

   // Parity-check columns per data bit; the leftmost entry belongs to the data MSB.
   localparam logic [4*4-1:0]  COL_S = {4'd7, 4'd14, 4'd13, 4'd11};
   localparam logic [11*5-1:0] COL_M = {5'd7, 5'd11, 5'd13, 5'd14, 5'd19, 5'd21,
                                        5'd22, 5'd25, 5'd26, 5'd28, 5'd31};
   localparam logic [26*6-1:0] COL_L = {6'd7,  6'd11, 6'd13, 6'd14, 6'd19, 6'd21,
                                        6'd22, 6'd25, 6'd26, 6'd28, 6'd31, 6'd35,
                                        6'd37, 6'd38, 6'd41, 6'd42, 6'd44, 6'd47,
                                        6'd49, 6'd50, 6'd52, 6'd55, 6'd56, 6'd59,
                                        6'd61, 6'd62};

   function automatic logic [5:0] col_of(input logic [1:0] sz, input int i);
      logic [5:0] c;
      c = '0;
      case (sz)
         2'b00:   if (i < 4)  c = {2'b00, COL_S[i*4 +: 4]};
         2'b01:   if (i < 11) c = {1'b0, COL_M[i*5 +: 5]};
         default: if (i < 26) c = COL_L[i*6 +: 6];
      endcase
      return c;
   endfunction

   // ---------------- stage 1: split and syndrome ----------------
   logic [KMAX-1:0] in_data;
   logic [5:0]      in_rx;
   logic [5:0]      in_calc;

   always_comb begin
      in_data = '0;
      in_rx   = '0;
      case (CODEWORD_WIDTH)
         2'b00: begin
            in_data[3:0] = DATA_IN[7:4];
            in_rx[3:0]   = DATA_IN[3:0];
         end
         2'b01: begin
            in_data[10:0] = DATA_IN[15:5];
            in_rx[4:0]    = DATA_IN[4:0];
         end
         default: begin
            in_data = DATA_IN[31:6];
            in_rx   = DATA_IN[5:0];
         end
      endcase
      in_calc = '0;
      for (int i = 0; i < KMAX; i++) begin
         if (in_data[i]) in_calc = in_calc ^ col_of(CODEWORD_WIDTH, i);
      end
   end

   logic            s1_valid;
   logic [1:0]      s1_size;
   logic [KMAX-1:0] s1_data;
   logic [5:0]      s1_syn;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_size  <= 2'b00;
         s1_data  <= '0;
         s1_syn   <= '0;
      end else begin
         s1_valid <= START;
         if (START) begin
            s1_size <= (CODEWORD_WIDTH == 2'b11) ? 2'b10 : CODEWORD_WIDTH;
            s1_data <= in_data;
            s1_syn  <= in_rx ^ in_calc;
         end
      end
   end

   // ---------------- stage 2: classify and correct ----------------
   logic [KMAX-1:0] flip_mask;
   logic [2:0]      syn_wt;
   logic [KMAX-1:0] cls_data;
   logic [1:0]      cls_err;

   always_comb begin
      flip_mask = '0;
      for (int i = 0; i < KMAX; i++) begin
         flip_mask[i] = (s1_syn != 6'd0) && (col_of(s1_size, i) == s1_syn);
      end
      syn_wt   = 3'($countones(s1_syn));
      cls_data = s1_data;
      cls_err  = 2'b00;
      if (s1_syn == 6'd0) begin
         cls_err = 2'b00;
      end else if (syn_wt == 3'd1) begin
         cls_err = 2'b01;    // check-bit error, data already correct
      end else if (syn_wt[0] && (|flip_mask)) begin
         cls_data = s1_data ^ flip_mask;
         cls_err  = 2'b01;
      end else begin
         cls_err = 2'b10;
      end
   end

   logic            s2_valid;
   logic [KMAX-1:0] s2_data;
   logic [1:0]      s2_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_err   <= 2'b00;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= cls_data;
            s2_err  <= cls_err;
         end
      end
   end

   // ---------------- output register and statistics ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         VALID_OUT     <= 1'b0;
         DATA_OUT      <= '0;
         NUM_OF_ERRORS <= 2'b00;
      end else begin
         VALID_OUT <= s2_valid;
         if (s2_valid) begin
            DATA_OUT      <= {{(AMBA_WORD-KMAX){1'b0}}, s2_data};
            NUM_OF_ERRORS <= s2_err;
         end
      end
   end

   // Counters follow the presented result; a clear in the same cycle overrides the increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         CORR_CNT   <= '0;
         UNCORR_CNT <= '0;
      end else if (CLR_CNT) begin
         CORR_CNT   <= '0;
         UNCORR_CNT <= '0;
      end else if (VALID_OUT) begin
         if ((NUM_OF_ERRORS == 2'b01) && !(&CORR_CNT))
            CORR_CNT <= CORR_CNT + CNT_WIDTH'(1);
         if ((NUM_OF_ERRORS == 2'b10) && !(&UNCORR_CNT))
            UNCORR_CNT <= UNCORR_CNT + CNT_WIDTH'(1);
      end
   end

endmodule
